// File: rtl/mdc_pkg.sv
// Shared types and defaults for the GCD datapath controller.
package mdc_pkg;

    // Operand/result width of the GCD datapath.
    localparam int MDC_WIDTH    = 8;
    // Default subtraction budget; (255,1) needs 254 iterations.
    localparam int MDC_MAX_ITER = 255;
    // Default iteration counter width; 2**MDC_ITER_W must exceed MDC_MAX_ITER.
    localparam int MDC_ITER_W   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        CAPT   = 3'd3,
        RESULT = 3'd4
    } mdc_ctrl_state_t;

endpackage

// File: rtl/mdc_iter_cnt.sv
// Iteration counter: synchronous clear, saturating increment and a
// terminal-count flag when the count equals MAX_ITER.
module mdc_iter_cnt #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ITER_W-1:0] o_cnt,
    output logic              o_tc
);

    localparam logic [ITER_W-1:0] LP_MAX = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] r_cnt;

    // Count register: clear wins over increment; increment stops at MAX_ITER.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LP_MAX);

endmodule

// File: rtl/mdc_ctrl.sv
// GCD datapath controller. Accepts an operand pair, loads the datapath,
// lets it iterate until it stops subtracting (or the iteration budget runs
// out), captures the result and presents it on the output channel.
//
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high. ready_o is high only in IDLE; valid_o is high only in
// RESULT, and dt_o/iter_o/err_o are stable while valid_o is high.
module mdc_ctrl
    import mdc_pkg::*;
#(
    parameter int WIDTH    = MDC_WIDTH,
    parameter int MAX_ITER = MDC_MAX_ITER,
    parameter int ITER_W   = MDC_ITER_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  dtx_i,
    input  logic [WIDTH-1:0]  dty_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  dt_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              err_o,
    output logic              enb_o,
    output logic              busy_o,
    output logic [WIDTH-1:0]  dpx_o,
    output logic [WIDTH-1:0]  dpy_o,
    input  logic              operation_i,
    input  logic [WIDTH-1:0]  dt_i
);

    mdc_ctrl_state_t r_state;
    mdc_ctrl_state_t w_next;

    logic [WIDTH-1:0]  r_dpx;
    logic [WIDTH-1:0]  r_dpy;
    logic [WIDTH-1:0]  r_dt;
    logic [ITER_W-1:0] r_iter;
    logic              r_err;

    logic              w_accept;
    logic              w_run;
    logic              w_inc;
    logic              w_timeout;
    logic              w_capt;
    logic [ITER_W-1:0] w_cnt;
    logic              w_tc;

    assign w_accept  = valid_i && (r_state == IDLE);
    assign w_run     = (r_state == RUN);
    assign w_inc     = w_run && operation_i && !w_tc;
    assign w_timeout = w_run && operation_i && w_tc;
    assign w_capt    = (r_state == CAPT);

    mdc_iter_cnt #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (w_accept),
        .i_inc (w_inc),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a subtraction at the terminal count aborts straight to RESULT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_next = LOAD;
            LOAD:    w_next = RUN;
            RUN: begin
                if (!operation_i) begin
                    w_next = CAPT;
                end else if (w_tc) begin
                    w_next = RESULT;
                end
            end
            CAPT:    w_next = RESULT;
            RESULT:  if (ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand registers toward the datapath, loaded on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dpx <= '0;
            r_dpy <= '0;
        end else if (w_accept) begin
            r_dpx <= dtx_i;
            r_dpy <= dty_i;
        end
    end

    // Result registers: cleared error on acceptance, filled at capture or timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dt   <= '0;
            r_iter <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_err  <= 1'b0;
        end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_dt   <= '0;
            r_iter <= w_cnt;
        end else if (w_capt) begin
            r_dt   <= dt_i;
            r_iter <= w_cnt;
        end
    end

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == RESULT);
    assign enb_o   = (r_state == LOAD) || (r_state == RUN);
    assign busy_o  = (r_state == RUN);
    assign dpx_o   = r_dpx;
    assign dpy_o   = r_dpy;
    assign dt_o    = r_dt;
    assign iter_o  = r_iter;
    assign err_o   = r_err;

endmodule

// File: tb/tb_mdc_ctrl.sv
// Directed bench for mdc_ctrl with a behavioural GCD subtraction datapath
// attached to each controller instance.
module tb_mdc_ctrl;
    import mdc_pkg::*;

    localparam int W  = 8;
    localparam int IW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A (default MAX_ITER) ----------------
    logic          valid_a, ready_a;
    logic [W-1:0]  dtx, dty;
    logic          a_ready_o, a_valid_o, a_err, a_enb, a_busy, a_op;
    logic [W-1:0]  a_dt_o, a_dpx, a_dpy, a_dt_i;
    logic [IW-1:0] a_iter;

    mdc_ctrl u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_a), .ready_o(a_ready_o),
        .dtx_i(dtx), .dty_i(dty),
        .valid_o(a_valid_o), .ready_i(ready_a),
        .dt_o(a_dt_o), .iter_o(a_iter), .err_o(a_err),
        .enb_o(a_enb), .busy_o(a_busy),
        .dpx_o(a_dpx), .dpy_o(a_dpy),
        .operation_i(a_op), .dt_i(a_dt_i)
    );

    // ---------------- DUT B (MAX_ITER = 4) ----------------
    logic          valid_b, ready_b;
    logic          b_ready_o, b_valid_o, b_err, b_enb, b_busy, b_op;
    logic [W-1:0]  b_dt_o, b_dpx, b_dpy, b_dt_i;
    logic [IW-1:0] b_iter;

    mdc_ctrl #(.WIDTH(W), .MAX_ITER(4), .ITER_W(IW)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_b), .ready_o(b_ready_o),
        .dtx_i(dtx), .dty_i(dty),
        .valid_o(b_valid_o), .ready_i(ready_b),
        .dt_o(b_dt_o), .iter_o(b_iter), .err_o(b_err),
        .enb_o(b_enb), .busy_o(b_busy),
        .dpx_o(b_dpx), .dpy_o(b_dpy),
        .operation_i(b_op), .dt_i(b_dt_i)
    );

    // ---------------- datapath models ----------------
    logic [W-1:0] ax, ay, bx, by;

    assign a_op = a_enb && a_busy && (ax != 0) && (ay != 0) && (ax != ay);
    assign b_op = b_enb && b_busy && (bx != 0) && (by != 0) && (bx != by);

    always @(posedge clk) begin
        if (a_enb && !a_busy) begin
            ax <= a_dpx; ay <= a_dpy;
        end else if (a_enb && a_busy) begin
            if (a_op) begin
                if (ax > ay) ax <= ax - ay; else ay <= ay - ax;
            end else begin
                a_dt_i <= (ax == 0) ? ay : ax;
            end
        end
    end

    always @(posedge clk) begin
        if (b_enb && !b_busy) begin
            bx <= b_dpx; by <= b_dpy;
        end else if (b_enb && b_busy) begin
            if (b_op) begin
                if (bx > by) bx <= bx - by; else by <= by - bx;
            end else begin
                b_dt_i <= (bx == 0) ? by : bx;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    logic [1:0] tr[0:511];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_a(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_dt, input bit push);
        @(negedge clk);
        chk("ready_before_accept", {31'd0, a_ready_o}, 1);
        valid_a = 1'b1; dtx = x; dty = y;
        if (push) exp_q.push_back(exp_dt);
        @(posedge clk); #1;
        valid_a = 1'b0;
        chk("ready_after_accept", {31'd0, a_ready_o}, 0);
    endtask

    task automatic wait_res_a(output int lat);
        lat = 0;
        tr[0] = {a_enb, a_busy};
        while (!a_valid_o && lat < 600) begin
            @(posedge clk); #1;
            lat++;
            if (lat < 512) tr[lat] = {a_enb, a_busy};
        end
        if (!a_valid_o) chk("result_wait_expired", 0, 1);
    endtask

    task automatic pop_dt_a();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("dt_o", {24'd0, a_dt_o}, {24'd0, e});
        end
    endtask

    task automatic check_res_a(input int exp_iter, input bit exp_err, input int exp_lat);
        int lat;
        wait_res_a(lat);
        chk("latency", lat, exp_lat);
        pop_dt_a();
        chk("iter_o", {24'd0, a_iter}, exp_iter);
        chk("err_o", {31'd0, a_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        chk("valid_drop", {31'd0, a_valid_o}, 0);
        chk("ready_back", {31'd0, a_ready_o}, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        valid_a = 0; valid_b = 0; ready_a = 1; ready_b = 1; dtx = 0; dty = 0;
        #12;
        chk("rst_ready", {31'd0, a_ready_o}, 1);
        chk("rst_valid", {31'd0, a_valid_o}, 0);
        chk("rst_enb", {31'd0, a_enb}, 0);
        chk("rst_busy", {31'd0, a_busy}, 0);
        chk("rst_err", {31'd0, a_err}, 0);
        chk("rst_dt", {24'd0, a_dt_o}, 0);
        chk("rst_iter", {24'd0, a_iter}, 0);
        @(negedge clk); rst = 1'b0;

        // Basic job (12,18): 2 subtractions, result 6 after E5.
        send_a(8'd12, 8'd18, 8'd6, 1);
        check_res_a(2, 0, 5);
        chk("seq_load", {30'd0, tr[0]}, 2);
        for (int i = 1; i <= 3; i++) chk("seq_run", {30'd0, tr[i]}, 3);
        chk("seq_capt", {30'd0, tr[4]}, 0);

        // Zero operands.
        send_a(8'd0, 8'd9, 8'd9, 1);
        check_res_a(0, 0, 3);
        send_a(8'd0, 8'd0, 8'd0, 1);
        check_res_a(0, 0, 3);

        // Worst case (255,1): 254 subtractions.
        send_a(8'd255, 8'd1, 8'd1, 1);
        check_res_a(254, 0, 257);

        // Back-pressure on (48,36) with a second request arriving meanwhile.
        @(negedge clk); ready_a = 1'b0;
        send_a(8'd48, 8'd36, 8'd12, 1);
        wait_res_a(lat);
        chk("bp_latency", lat, 6);
        pop_dt_a();
        chk("bp_iter", {24'd0, a_iter}, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) begin valid_a = 1'b1; dtx = 8'd21; dty = 8'd14; end
            @(posedge clk); #1;
            chk("bp_valid_hold", {31'd0, a_valid_o}, 1);
            chk("bp_dt_hold", {24'd0, a_dt_o}, 12);
            chk("bp_ready_low", {31'd0, a_ready_o}, 0);
        end
        @(negedge clk); ready_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, a_valid_o}, 0);
        chk("bp_release_ready", {31'd0, a_ready_o}, 1);
        exp_q.push_back(8'd7);
        @(posedge clk); #1;
        valid_a = 1'b0;
        chk("bp_second_accepted", {31'd0, a_ready_o}, 0);
        check_res_a(2, 0, 5);

        // Timeout on the MAX_ITER=4 instance with (255,1).
        @(negedge clk);
        valid_b = 1'b1; dtx = 8'd255; dty = 8'd1;
        @(posedge clk); #1;
        valid_b = 1'b0;
        lat = 0;
        while (!b_valid_o && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) chk("to_enb_before_abort", {31'd0, b_enb}, 1);
        end
        chk("to_latency", lat, 6);
        chk("to_enb_low", {31'd0, b_enb}, 0);
        chk("to_err", {31'd0, b_err}, 1);
        chk("to_dt", {24'd0, b_dt_o}, 0);
        chk("to_iter", {24'd0, b_iter}, 4);
        @(posedge clk); #1;
        chk("to_valid_drop", {31'd0, b_valid_o}, 0);

        // Reset during RUN of (200,3), then a fresh job (7,21).
        send_a(8'd200, 8'd3, 8'd0, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_in_run", {31'd0, a_busy}, 1);
        #2; rst = 1'b1; #1;
        chk("mid_rst_ready", {31'd0, a_ready_o}, 1);
        chk("mid_rst_valid", {31'd0, a_valid_o}, 0);
        chk("mid_rst_enb", {31'd0, a_enb}, 0);
        chk("mid_rst_busy", {31'd0, a_busy}, 0);
        chk("mid_rst_err", {31'd0, a_err}, 0);
        chk("mid_rst_dt", {24'd0, a_dt_o}, 0);
        chk("mid_rst_iter", {24'd0, a_iter}, 0);
        chk("mid_rst_dpx", {24'd0, a_dpx}, 0);
        chk("mid_rst_dpy", {24'd0, a_dpy}, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", {31'd0, a_valid_o}, 0);
        end
        send_a(8'd7, 8'd21, 8'd7, 1);
        check_res_a(2, 0, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
